// File: rtl/float_addsub_seq.sv
// Issue/retire sequencer in front of the fixed-latency float add core: one op in flight,
// subtract becomes add with B's sign flipped. Optional sticky overflow via FLOAT_SEQ_STICKY_OVF_EN.
module float_addsub_seq #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic [31:0] core_s,
    input  logic        core_ovf,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_s,
    output logic        res_ovf,
    output logic        busy,
    output logic        ovf_sticky,
    input  logic        clr_ovf
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;

    assign accept  = (state == IDLE) && cmd_valid;
    assign capture = (state == BUSY) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_valid) state_nx = BUSY;
            BUSY:    if (cnt == 4'd0) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands stay put after accept so the core sees stable inputs for the whole latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            core_a  <= 32'd0;
            core_b  <= 32'd0;
            res_s   <= 32'd0;
            res_ovf <= 1'b0;
        end else begin
            if (accept) begin
                core_a <= cmd_a;
                core_b <= cmd_op ? (cmd_b ^ 32'h8000_0000) : cmd_b;
                cnt    <= 4'(LAT);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                res_s   <= core_s;
                res_ovf <= core_ovf;
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

`ifdef FLOAT_SEQ_STICKY_OVF_EN
    // A new overflow outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk) begin
        if (rst)                        ovf_sticky <= 1'b0;
        else if (capture && core_ovf)   ovf_sticky <= 1'b1;
        else if (clr_ovf)               ovf_sticky <= 1'b0;
    end
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = clr_ovf;
    assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_float_addsub_seq.sv
// Directed bench for float_addsub_seq: instance 0 uses LAT=3, instance 1 uses LAT=0.
module tb_float_addsub_seq;

`ifdef FLOAT_SEQ_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic        cmd_op    [2];
    logic [31:0] cmd_a     [2];
    logic [31:0] cmd_b     [2];
    logic [31:0] core_a    [2];
    logic [31:0] core_b    [2];
    logic [31:0] core_s    [2];
    logic        core_ovf  [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [31:0] res_s     [2];
    logic        res_ovf   [2];
    logic        busy      [2];
    logic        ovf_sticky[2];
    logic        clr_ovf   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h40400000_BF800000: return 32'h40000000;
            64'h7F7FFFFF_7F7FFFFF: return 32'h7F800000;
            default:               return a ^ b;
        endcase
    endfunction

    function automatic logic ovf_fn(input logic [31:0] a, input logic [31:0] b);
        return (a == 32'h7F7FFFFF) && (b == 32'h7F7FFFFF);
    endfunction

    assign core_s[0]   = core_fn(core_a[0], core_b[0]);
    assign core_ovf[0] = ovf_fn(core_a[0], core_b[0]);
    assign core_s[1]   = core_fn(core_a[1], core_b[1]);
    assign core_ovf[1] = ovf_fn(core_a[1], core_b[1]);

    float_addsub_seq #(.LAT(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .core_a(core_a[0]), .core_b(core_b[0]),
        .core_s(core_s[0]), .core_ovf(core_ovf[0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0]), .res_s(res_s[0]), .res_ovf(res_ovf[0]),
        .busy(busy[0]), .ovf_sticky(ovf_sticky[0]), .clr_ovf(clr_ovf[0])
    );

    float_addsub_seq #(.LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .core_a(core_a[1]), .core_b(core_b[1]),
        .core_s(core_s[1]), .core_ovf(core_ovf[1]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1]), .res_s(res_s[1]), .res_ovf(res_ovf[1]),
        .busy(busy[1]), .ovf_sticky(ovf_sticky[1]), .clr_ovf(clr_ovf[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        cmd_op[0] = op; cmd_a[0] = a; cmd_b[0] = b; cmd_valid[0] = 1'b1;
        step();
        cmd_valid[0] = 1'b0;
    endtask

    // Cycles from accept until res_valid, capped at 20.
    task automatic wait_res(output int n);
        n = 0;
        while (res_valid[0] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic release_res();
        res_ready[0] = 1'b1;
        step();
        res_ready[0] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (cmd_ready[0] !== 1'b1 || res_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b, want 1 0 0", cmd_ready[0], res_valid[0], busy[0]);
        end
        checks++;
        if (core_a[0] !== 32'd0 || core_b[0] !== 32'd0 || res_s[0] !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: core_a=%h core_b=%h res_s=%h, want 0", core_a[0], core_b[0], res_s[0]);
        end
        checks++;
        if (res_ovf[0] !== 1'b0 || ovf_sticky[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: res_ovf=%b sticky=%b, want 0 0", res_ovf[0], ovf_sticky[0]);
        end
    endtask

    task automatic test_add();
        int n;
        issue(1'b0, 32'h3F800000, 32'h40000000);
        checks++;
        if (core_a[0] !== 32'h3F800000 || core_b[0] !== 32'h40000000) begin
            errors++;
            $display("FAIL add_operands: a=%h b=%h, want 3f800000 40000000", core_a[0], core_b[0]);
        end
        checks++;
        if (busy[0] !== 1'b1 || cmd_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL add_busy: busy=%b ready=%b, want 1 0", busy[0], cmd_ready[0]);
        end
        wait_res(n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL add_latency: got %0d cycles, want 4", n);
        end
        checks++;
        if (res_s[0] !== 32'h40400000 || res_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL add_result: s=%h ovf=%b, want 40400000 0", res_s[0], res_ovf[0]);
        end
        release_res();
        checks++;
        if (res_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL add_release: valid=%b ready=%b, want 0 1", res_valid[0], cmd_ready[0]);
        end
    endtask

    task automatic test_sub();
        int n;
        issue(1'b1, 32'h40400000, 32'h3F800000);
        checks++;
        if (core_b[0] !== 32'hBF800000) begin
            errors++;
            $display("FAIL sub_flip: core_b=%h, want bf800000", core_b[0]);
        end
        wait_res(n);
        checks++;
        if (n !== 4 || res_s[0] !== 32'h40000000) begin
            errors++;
            $display("FAIL sub_result: n=%0d s=%h, want 4 40000000", n, res_s[0]);
        end
        release_res();
    endtask

    task automatic test_backpressure();
        int n;
        issue(1'b0, 32'h3F800000, 32'h40000000);
        wait_res(n);
        for (int i = 0; i < 5; i++) begin
            cmd_valid[0] = (i % 2 == 0);
            cmd_a[0]     = 32'h12345678;
            step();
            checks++;
            if (res_s[0] !== 32'h40400000 || cmd_ready[0] !== 1'b0 || core_a[0] !== 32'h3F800000
                || res_valid[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: s=%h ready=%b core_a=%h valid=%b", i, res_s[0],
                         cmd_ready[0], core_a[0], res_valid[0]);
            end
        end
        cmd_valid[0] = 1'b0;
        release_res();
        checks++;
        if (cmd_ready[0] !== 1'b1 || res_valid[0] !== 1'b0 || core_a[0] !== 32'h3F800000) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b core_a=%h, want 1 0 3f800000",
                     cmd_ready[0], res_valid[0], core_a[0]);
        end
    endtask

    task automatic test_overflow();
        int n;
        issue(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF);
        wait_res(n);
        checks++;
        if (res_ovf[0] !== 1'b1 || res_s[0] !== 32'h7F800000) begin
            errors++;
            $display("FAIL ovf_flag: ovf=%b s=%h, want 1 7f800000", res_ovf[0], res_s[0]);
        end
        release_res();
        checks++;
        if (ovf_sticky[0] !== STICKY) begin
            errors++;
            $display("FAIL ovf_sticky_set: got %b want %b", ovf_sticky[0], STICKY);
        end
        issue(1'b0, 32'h3F800000, 32'h40000000);
        wait_res(n);
        release_res();
        checks++;
        if (res_ovf[0] !== 1'b0 || ovf_sticky[0] !== STICKY) begin
            errors++;
            $display("FAIL ovf_persist: res_ovf=%b sticky=%b, want 0 %b", res_ovf[0], ovf_sticky[0], STICKY);
        end
        // Clear held through the capture edge of a new overflow.
        issue(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF);
        clr_ovf[0] = 1'b1;
        wait_res(n);
        clr_ovf[0] = 1'b0;
        checks++;
        if (ovf_sticky[0] !== STICKY) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b want %b", ovf_sticky[0], STICKY);
        end
        release_res();
        clr_ovf[0] = 1'b1;
        step();
        clr_ovf[0] = 1'b0;
        checks++;
        if (ovf_sticky[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", ovf_sticky[0]);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(1'b1, 32'h40400000, 32'h3F800000);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (core_a[0] !== 32'd0 || core_b[0] !== 32'd0 || res_s[0] !== 32'd0 || busy[0] !== 1'b0
            || res_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: a=%h b=%h s=%h busy=%b valid=%b ready=%b", core_a[0], core_b[0],
                     res_s[0], busy[0], res_valid[0], cmd_ready[0]);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (res_valid[0] === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_no_result: res_valid seen %0d cycles, want 0", seen);
        end
    endtask

    task automatic test_back_to_back(input int k, input int period);
        logic [31:0] exp_q[$];
        logic [31:0] a, b;
        logic        op;
        int          idx = 0;
        int          ri = 0;
        int          last = -1;
        logic        acc;
        res_ready[k] = 1'b1;
        a = 32'h40000000; b = 32'h3F000000; op = 1'b0;
        cmd_a[k] = a; cmd_b[k] = b; cmd_op[k] = op;
        for (int cyc = 0; cyc < 50; cyc++) begin
            cmd_valid[k] = (cyc < 40);
            acc = cmd_valid[k] && cmd_ready[k];
            if (res_valid[k] === 1'b1) begin
                checks++;
                if (ri >= exp_q.size() || res_s[k] !== exp_q[ri]) begin
                    errors++;
                    $display("FAIL b2b_result[k=%0d,%0d]: got %h want %h", k, ri, res_s[k],
                             (ri < exp_q.size()) ? exp_q[ri] : 32'hx);
                end
                ri++;
            end
            step();
            if (acc) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== period) begin
                        errors++;
                        $display("FAIL b2b_period[k=%0d]: got %0d want %0d", k, cyc - last, period);
                    end
                end
                last = cyc;
                exp_q.push_back(a ^ (op ? (b ^ 32'h80000000) : b));
                idx++;
                a = 32'h40000000 + 32'(idx) * 32'h1111;
                b = 32'h3F000000 + 32'(idx) * 32'h7;
                op = idx[0];
                cmd_a[k] = a; cmd_b[k] = b; cmd_op[k] = op;
            end
        end
        cmd_valid[k] = 1'b0;
        res_ready[k] = 1'b0;
        checks++;
        if (ri !== exp_q.size() || ri < 5) begin
            errors++;
            $display("FAIL b2b_count[k=%0d]: results %0d accepts %0d", k, ri, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd_op[k] = 1'b0; cmd_a[k] = 32'd0; cmd_b[k] = 32'd0;
            res_ready[k] = 1'b0; clr_ovf[k] = 1'b0;
        end
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back(0, 6);
        test_back_to_back(1, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/float_addsub_seq.md
# float_addsub_seq

Issue/retire sequencer that sits directly upstream of the 32-bit floating-point add core in the ALU float path. It accepts add or subtract commands over a valid/ready handshake and drives the core's operand ports, turning subtraction into addition by flipping the sign bit of B. It waits out the core's fixed pipeline latency, then captures the sum and overflow flag and holds them behind a valid/ready result handshake. One command is in flight at a time.

## Interface
- LAT, 3: core latency in clock edges from stable operands to valid `core_s`/`core_ovf`; legal range 0..15.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  1  0 = add, 1 = subtract.
- cmd_a  in  32  IEEE-754 single operand A.
- cmd_b  in  32  IEEE-754 single operand B.
- core_a  out  32  registered operand to the add core.
- core_b  out  32  registered operand to the add core; sign bit already flipped for subtract.
- core_s  in  32  core result.
- core_ovf  in  1  core overflow flag.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes the result.
- res_s  out  32  captured result.
- res_ovf  out  1  captured overflow.
- busy  out  1  high in BUSY or DONE.
- ovf_sticky  out  1  sticky overflow status (see Configuration).
- clr_ovf  in  1  clears `ovf_sticky`.

## Operation
- States: IDLE, BUSY, DONE. 4-bit down-counter `cnt`.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, the sequencer:
  - latches `core_a`=`cmd_a`;
  - latches `core_b`=`cmd_b ^ 32'h80000000` when `cmd_op`=1, else `cmd_b`;
  - loads `cnt`=LAT and moves to BUSY.
- BUSY:
  - `cnt`≠0: decrement `cnt`.
  - `cnt`==0: capture `res_s`=`core_s` and `res_ovf`=`core_ovf` on that edge, then move to DONE.
- DONE: `res_valid`=1. `res_s`/`res_ovf` are held stable until `res_ready`=1, then the block moves to IDLE. There is no same-cycle re-accept.
- `core_a`/`core_b` hold their values through BUSY, DONE and the following IDLE until the next accept.
- `cmd_valid` is ignored outside IDLE. There is no command queue.
- No special-value handling (NaN, Inf, denormal); operands pass bit-exact apart from the subtract sign flip.

## Timing
- Reset (`rst`=1 at an edge): state=IDLE, `cnt`=0, `core_a`=`core_b`=`res_s`=0, `res_valid`=`res_ovf`=`busy`=`ovf_sticky`=0. `cmd_ready`=1 from the first cycle after reset.
- Accept at edge E0; `core_a`/`core_b` are valid after E0. Capture occurs at edge E(LAT+1), so `res_valid` is high LAT+1 cycles after accept.
- `res_ready` sampled high in DONE at edge Ek: IDLE after Ek, next accept no earlier than E(k+1).
- With `res_ready` tied high, back-to-back command period is LAT+3 cycles.
- Reset mid-BUSY or mid-DONE: the op is discarded and no `res_valid` pulse is produced.
- `cmd_ready`, `res_valid` and `busy` decode from the state register only. None is combinational from inputs.

## Configuration
- FLOAT_SEQ_STICKY_OVF_EN defined:
  - `ovf_sticky` sets at a capture edge where `core_ovf`=1.
  - It clears on `clr_ovf`=1 or `rst`.
  - Set wins when set and `clr_ovf` coincide.
- Not defined: `ovf_sticky` is tied 0 and `clr_ovf` is ignored. Both ports remain present.

## Test plan
- Add, LAT=3: op=0, a=32'h3F800000, b=32'h40000000, core model returns 32'h40400000 → `core_b`=32'h40000000, `res_valid` rises 4 cycles after accept, `res_s`=32'h40400000, `res_ovf`=0.
- Subtract: op=1, a=32'h40400000, b=32'h3F800000 → `core_b`=32'hBF800000, `res_s`=32'h40000000.
- Backpressure: `res_ready`=0 for 5 cycles in DONE with `cmd_valid` pulsing → `res_s` stable, `cmd_ready`=0, no extra accepts. Raise `res_ready` → IDLE next cycle, `cmd_ready`=1.
- Overflow: a=b=32'h7F7FFFFF, model `core_ovf`=1 → `res_ovf`=1.
  - With macro: `ovf_sticky`=1 and it persists through a following clean op.
  - `clr_ovf` coinciding with a new overflow capture → stays 1.
  - `clr_ovf` alone → 0.
  - Without macro: `ovf_sticky` stays 0.
- Reset at `cnt`=2 in BUSY → all outputs 0 next cycle, no `res_valid` ever, `cmd_ready`=1.
- Throughput, LAT=0 and LAT=3, `res_ready`=1, continuous `cmd_valid` → accepts every 3 and 6 cycles respectively; results match the model in order.
